// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage and imem.
interface fetch_unit_if;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_RData;

  modport master (
    output IMem_Req,
    output IMem_Addr,
    input  IMem_Ack,
    input  IMem_RData
  );

  modport slave (
    input  IMem_Req,
    input  IMem_Addr,
    output IMem_Ack,
    output IMem_RData
  );
endinterface

// File: rtl/fetch_unit.sv
// PC / instruction fetch stage of the single-cycle core.
// Fetches one instruction per slot, computes next PC, halts on misalignment.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic [31:0] ImmExt,
  input  logic        Stall,
  fetch_unit_if.master imem,
  output logic [31:0] Instr,
  output logic [6:0]  OP_Code,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PC_Plus4,
  output logic        Fault,
  output logic [31:0] RetireCount
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        fault_q, fault_d;
  logic [31:0] rc_q, rc_d;
  logic [31:0] pc_plus4;
  logic [31:0] pc_rel;
  logic [31:0] target;
  logic        take;

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_rel   = pc_q + ImmExt;

  // Jump wins outright so an undefined Branch never leaks into the target.
  always_comb begin
    take = 1'b0;
    if (Jump)
      take = 1'b1;
    else if (Branch && Zero)
      take = 1'b1;
    target = take ? pc_rel : pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSTR;
      fault_q <= 1'b0;
      rc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
      rc_q    <= rc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    rc_d    = rc_q;
    unique case (state_q)
      FETCH: begin
        if (imem.IMem_Ack) begin
          ir_d    = imem.IMem_RData;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!Stall) begin
          if (target[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = target;
            rc_d    = rc_q + 32'd1;
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = HALT;
        fault_d = 1'b1;
      end
    endcase
  end

  assign imem.IMem_Req  = (state_q == FETCH);
  assign imem.IMem_Addr = pc_q;
  assign InstrValid     = (state_q == EXEC);
  assign Instr          = InstrValid ? ir_q : NOP_INSTR;
  assign OP_Code        = Instr[6:0];
  assign PC             = pc_q;
  assign PC_Plus4       = pc_plus4;
  assign Fault          = fault_q;
  assign RetireCount    = rc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, next-PC, stall, wrap, fault.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        Branch, Zero, Jump, Stall;
  logic [31:0] ImmExt;
  logic [31:0] Instr, PC, PC_Plus4, RetireCount;
  logic [6:0]  OP_Code;
  logic        InstrValid, Fault;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_rc = 0;
  int          vcnt;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .Branch(Branch), .Zero(Zero), .Jump(Jump),
    .ImmExt(ImmExt), .Stall(Stall),
    .imem(imem.master),
    .Instr(Instr), .OP_Code(OP_Code),
    .InstrValid(InstrValid), .PC(PC),
    .PC_Plus4(PC_Plus4), .Fault(Fault),
    .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic ctl(input logic br, input logic z,
                     input logic jp, input logic [31:0] imm);
    Branch = br; Zero = z; Jump = jp; ImmExt = imm;
  endtask

  // Zero-wait fetch at pc, one EXEC with given controls; ends at next negedge.
  task automatic fetch_exec(input string tag, input logic [31:0] pc,
                            input logic [31:0] ins, input logic br,
                            input logic z, input logic jp,
                            input logic [31:0] imm);
    check({tag, ".req"}, {31'd0, imem.IMem_Req}, 32'd1);
    check({tag, ".addr"}, imem.IMem_Addr, pc);
    imem.IMem_Ack = 1'b1; imem.IMem_RData = ins;
    @(posedge clk); @(negedge clk);
    imem.IMem_Ack = 1'b0;
    ctl(br, z, jp, imm);
    check({tag, ".valid"}, {31'd0, InstrValid}, 32'd1);
    check({tag, ".instr"}, Instr, ins);
    check({tag, ".pc"}, PC, pc);
    check({tag, ".pc4"}, PC_Plus4, pc + 32'd4);
    @(posedge clk); @(negedge clk);
    ctl(1'b0, 1'b0, 1'b0, 32'd0);
    exp_rc++;
    check({tag, ".rc"}, RetireCount, exp_rc);
  endtask

  initial begin
    rst = 1'b1; Stall = 1'b0;
    ctl(1'b0, 1'b0, 1'b0, 32'd0);
    imem.IMem_Ack = 1'b0; imem.IMem_RData = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.req", {31'd0, imem.IMem_Req}, 32'd1);
    check("rst.pc", PC, RPC);
    check("rst.valid", {31'd0, InstrValid}, 32'd0);
    check("rst.instr", Instr, NOP);
    check("rst.fault", {31'd0, Fault}, 32'd0);
    check("rst.rc", RetireCount, 32'd0);

    // Test 1: zero-wait fetch at reset PC
    rst = 1'b0;
    check("t1.req", {31'd0, imem.IMem_Req}, 32'd1);
    check("t1.addr", imem.IMem_Addr, 32'h100);
    imem.IMem_Ack = 1'b1; imem.IMem_RData = 32'h0050_0093;
    @(posedge clk); @(negedge clk);
    imem.IMem_Ack = 1'b0;
    check("t1.valid", {31'd0, InstrValid}, 32'd1);
    check("t1.instr", Instr, 32'h0050_0093);
    check("t1.op", {25'd0, OP_Code}, 32'h13);
    check("t1.pc", PC, 32'h100);
    check("t1.pc4", PC_Plus4, 32'h104);
    @(posedge clk); @(negedge clk);
    exp_rc++;
    check("t1.nreq", {31'd0, imem.IMem_Req}, 32'd1);
    check("t1.naddr", imem.IMem_Addr, 32'h104);
    check("t1.rc", RetireCount, 32'd1);

    // Test 2: three wait states, then jump to 0x200
    for (int i = 0; i < 4; i++) begin
      check("t2.req", {31'd0, imem.IMem_Req}, 32'd1);
      check("t2.addr", imem.IMem_Addr, 32'h104);
      check("t2.valid", {31'd0, InstrValid}, 32'd0);
      check("t2.instr", Instr, NOP);
      if (i == 3) begin
        imem.IMem_Ack = 1'b1; imem.IMem_RData = 32'h0fc0_006f;
      end
      @(posedge clk); @(negedge clk);
    end
    imem.IMem_Ack = 1'b0;
    check("t2.valid1", {31'd0, InstrValid}, 32'd1);
    check("t2.instr1", Instr, 32'h0fc0_006f);
    ctl(1'b0, 1'b0, 1'b1, 32'h0000_00fc);
    @(posedge clk); @(negedge clk);
    ctl(1'b0, 1'b0, 1'b0, 32'd0);
    exp_rc++;
    check("t2.rc", RetireCount, exp_rc);

    // Test 3: branch taken / not taken
    fetch_exec("t3a", 32'h200, 32'hfe00_0ce3, 1'b1, 1'b1, 1'b0, 32'hffff_fff8);
    fetch_exec("t3b", 32'h1f8, 32'h0080_006f, 1'b0, 1'b0, 1'b1, 32'h8);
    fetch_exec("t3c", 32'h200, 32'hfe00_0ce3, 1'b1, 1'b0, 1'b0, 32'hffff_fff8);
    fetch_exec("t3d", 32'h204, 32'h0fc0_006f, 1'b0, 1'b0, 1'b1, 32'hfc);

    // Test 4: jump with Branch undefined
    fetch_exec("t4", 32'h300, 32'h0100_00ef, 1'bx, 1'b0, 1'b1, 32'h10);
    check("t4.next", imem.IMem_Addr, 32'h310);

    // Test 5: two stall cycles
    imem.IMem_Ack = 1'b1; imem.IMem_RData = 32'h0000_0033;
    @(posedge clk); @(negedge clk);
    imem.IMem_Ack = 1'b0;
    vcnt = 0;
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (InstrValid) vcnt++;
      check("t5.pc", PC, 32'h310);
      check("t5.rcst", RetireCount, exp_rc);
      if (i == 2) Stall = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    exp_rc++;
    check("t5.vcnt", vcnt, 32'd3);
    check("t5.rc", RetireCount, exp_rc);
    check("t5.next", imem.IMem_Addr, 32'h314);

    // Test 5b: wrap past top of address space
    fetch_exec("t5c", 32'h314, 32'h0000_006f, 1'b0, 1'b0, 1'b1, 32'hffff_fce8);
    fetch_exec("t5d", 32'hffff_fffc, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'd0);
    check("t5.wrap", imem.IMem_Addr, 32'h0);

    // Test 6: misaligned jump halts, late acks ignored
    imem.IMem_Ack = 1'b1; imem.IMem_RData = 32'h0060_006f;
    @(posedge clk); @(negedge clk);
    ctl(1'b0, 1'b0, 1'b1, 32'h6);
    @(posedge clk); @(negedge clk);
    ctl(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("t6.fault", {31'd0, Fault}, 32'd1);
      check("t6.req", {31'd0, imem.IMem_Req}, 32'd0);
      check("t6.valid", {31'd0, InstrValid}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
    check("t6.pc", PC, 32'h0);
    check("t6.rc", RetireCount, exp_rc);
    imem.IMem_Ack = 1'b0;

    // Reset out of HALT
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_rc = 0;
    check("t6.hfault", {31'd0, Fault}, 32'd0);
    check("t6.hpc", PC, RPC);
    check("t6.hrc", RetireCount, 32'd0);
    check("t6.hreq", {31'd0, imem.IMem_Req}, 32'd1);

    // Retire once, then reset mid-wait
    fetch_exec("t6e", 32'h100, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6.wait", imem.IMem_Addr, 32'h104);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_rc = 0;
    check("t6.wpc", PC, RPC);
    check("t6.wrc", RetireCount, 32'd0);
    check("t6.wfault", {31'd0, Fault}, 32'd0);
    fetch_exec("t6f", 32'h100, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter stage of the single-cycle core, directly upstream of the control unit. It holds the PC and fetches one 32-bit instruction per instruction slot over a req/ack handshake with instruction memory. It presents that instruction (and its 7-bit opcode) to decode and execute. It computes the next PC from the control unit's `Branch`/`Jump` outputs, the ALU `Zero` flag and the sign-extended immediate.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; must be word-aligned.
- `NOP_INSTR`, default `32'h0000_0013`: instruction presented when no valid instruction is held (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `Branch` in 1: from the control unit.
- `Zero` in 1: from the ALU.
- `Jump` in 1: from the control unit.
- `ImmExt` in 32: sign-extended byte offset for branch/jump.
- `Stall` in 1: hold the current instruction in execute (e.g. data memory busy).
- `IMem_Req` in/out: out 1, fetch request.
- `IMem_Addr` out 32: fetch address (= PC).
- `IMem_Ack` in 1: fetch data valid this cycle.
- `IMem_RData` in 32: fetched instruction.
- `Instr` out 32: current instruction.
- `OP_Code` out 7: `Instr[6:0]`, feeds the control unit.
- `InstrValid` out 1: `Instr` is being executed this cycle.
- `PC` out 32: address of `Instr`.
- `PC_Plus4` out 32: `PC + 4`, the JAL link value.
- `Fault` out 1: misaligned next-PC detected; core halted.
- `RetireCount` out 32: number of instructions retired.

## Operation
- FSM with states FETCH, EXEC and HALT.
- Outputs decoded from state:
  - `IMem_Req = (state==FETCH)`
  - `InstrValid = (state==EXEC)`
  - `Instr = InstrValid ? IR : NOP_INSTR`
  - `IMem_Addr = PC`
- **FETCH**: `IMem_Req` stays high and `IMem_Addr` stays stable until `IMem_Ack`. On `IMem_Ack`, `IR <= IMem_RData` and the next state is EXEC. An ack in the same cycle as the request is legal (zero-wait).
- **EXEC**: `Branch`, `Zero`, `Jump`, `ImmExt` and `Stall` are sampled this cycle.
  - If `Stall`=1: remain in EXEC; PC, IR and `RetireCount` are unchanged.
  - Otherwise the target is:
    - `PC + ImmExt` if `Jump`=1 (`Branch` is ignored, including X);
    - else `PC + ImmExt` if `Branch & Zero`;
    - else `PC + 4`.
  - If `target[1:0] != 0`: go to HALT, set `Fault <= 1`, keep PC unchanged, keep `RetireCount` unchanged.
  - Else: `PC <= target`, `RetireCount <= RetireCount + 1`, go to FETCH.
- **HALT**: terminal until `rst`. `IMem_Req`=0, `InstrValid`=0, `Fault`=1.
- `IMem_Ack` is ignored outside FETCH.
- Arithmetic: all PC and `RetireCount` arithmetic is modulo 2^32.
  - `PC = 32'hFFFF_FFFC` with `PC + 4` wraps to 0.
  - `RetireCount` wraps from `32'hFFFF_FFFF` to 0.
- Downstream contract: the register-file and data-memory write enables must be gated with `InstrValid`, because the control unit asserts `RegWrite` in its default case. `NOP_INSTR` keeps decode harmless.

## Timing
- Reset values, taking effect on the edge where `rst`=1:
  - state = FETCH, `PC` = `RESET_PC`, `IR` = `NOP_INSTR`;
  - `Fault` = 0, `RetireCount` = 0.
- While `rst` is high, the registered outputs hold these reset values.
- `rst` asserted in any state, including mid-wait in FETCH or in HALT, aborts the current activity. After the edge the block is in FETCH at `RESET_PC`. A late ack arriving for the aborted fetch is treated as the ack for `RESET_PC`; the instruction memory must be reset in the same cycle.
- The first cycle after `rst` deasserts has `IMem_Req`=1 with `IMem_Addr=RESET_PC`.
- Latency: with a zero-wait memory, each instruction takes 2 cycles (1 FETCH + 1 EXEC). Each wait state adds 1 cycle, and each `Stall` cycle adds 1 cycle.
- `PC_Plus4` and `OP_Code` are combinational from the registers and valid in the same EXEC cycle.
- The next-PC decision uses the inputs present in the final, non-stalled EXEC cycle only.

## Test plan
1. **Reset and zero-wait fetch**: `RESET_PC=0x100`, release `rst`, ack in the same cycle with `0x00500093`.
   - Required: next cycle `InstrValid`=1, `Instr=0x00500093`, `OP_Code=0x13`, `PC=0x100`, `PC_Plus4=0x104`.
   - Required: the following cycle has `IMem_Req`=1 with `IMem_Addr=0x104`, and `RetireCount`=1.
2. **Wait states**: delay `IMem_Ack` by 3 cycles.
   - Required: `IMem_Req`=1 and `IMem_Addr` stable for 4 cycles.
   - Required: throughout, `InstrValid`=0 and `Instr=0x00000013`.
3. **Branch**: in EXEC at `PC=0x200`, `Branch`=1, `ImmExt=0xFFFF_FFF8`.
   - `Zero`=1: next fetch at `0x1F8`.
   - `Zero`=0: next fetch at `0x204`.
4. **Jump**: at `PC=0x300`, `Jump`=1, `Branch`=X, `ImmExt=0x10`.
   - Required: `PC_Plus4=0x304` during EXEC, next fetch at `0x310`.
5. **Stall and wrap**:
   - `Stall`=1 for 2 cycles: `InstrValid` is high for 3 cycles and `RetireCount` increments exactly once.
   - `PC=0xFFFF_FFFC` with no branch: next fetch at `0x0`.
6. **Fault and reset**:
   - `Jump` with `ImmExt=0x6`: `Fault`=1, `PC` unchanged, `IMem_Req` stays 0 for 10 or more cycles.
   - `rst` in FETCH mid-wait or in HALT: `Fault`=0, `PC=RESET_PC`, `RetireCount`=0.
